// File: rtl/fft_ram_rd_arb_if.sv
// Request, RAM read-port and output-stream signals of the FFT RAM read arbiter.
// master = requester/RAM side (testbench or system), slave = fft_ram_rd_arb.
interface fft_ram_rd_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] start0;
    logic [ADDR_W-1:0] start1;
    logic [ADDR_W-1:0] len0;
    logic [ADDR_W-1:0] len1;
    logic              ack0;
    logic              ack1;
    logic [ADDR_W-1:0] ram_rd_addr;
    logic [DATA_W-1:0] ram_rd_data;
    logic [DATA_W-1:0] out_data;
    logic              out_vld;
    logic              out_id;
    logic              out_last;
    logic              busy;

    modport master (
        output req0, req1, start0, start1, len0, len1, ram_rd_data,
        input  ack0, ack1, ram_rd_addr, out_data, out_vld, out_id, out_last, busy
    );

    modport slave (
        input  req0, req1, start0, start1, len0, len1, ram_rd_data,
        output ack0, ack1, ram_rd_addr, out_data, out_vld, out_id, out_last, busy
    );
endinterface

// File: rtl/fft_ram_rd_arb.sv
// Round-robin burst read arbiter for the FFT RAM read port (two requesters).
// Optional macro FFT_RD_BITREV_EN: requester 0 addresses are bit-reversed.
module fft_ram_rd_arb #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    fft_ram_rd_arb_if.slave   bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              armed;
    logic              rr_last;
    logic              grant;
    logic              grant_id;
    logic [ADDR_W-1:0] grant_start;
    logic [ADDR_W-1:0] grant_len;
    logic              cnt_done;
    logic              advance;
    logic              id_nxt;
    logic [ADDR_W-1:0] lin_nxt;
    logic [ADDR_W-1:0] addr_nxt;

    logic [ADDR_W-1:0] lin_p0;
    logic [ADDR_W-1:0] cnt_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              id_p0;
    logic              ack0_p0;
    logic              ack1_p0;

    logic              vld_p1;
    logic              last_p1;
    logic              id_p1;
    logic [DATA_W-1:0] data_p1;

`ifdef FFT_RD_BITREV_EN
    function automatic logic [ADDR_W-1:0] bit_reverse(input logic [ADDR_W-1:0] lin);
        logic [ADDR_W-1:0] rev;
        for (int i = 0; i < ADDR_W; i++) begin
            rev[i] = lin[ADDR_W-1-i];
        end
        return rev;
    endfunction
`endif

    assign cnt_done = (cnt_p0 == '0);

    // armed keeps the first edge after reset release from granting
    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        grant_id  = 1'b0;
        case (state)
            IDLE: begin
                if (armed && (bus.req0 || bus.req1)) begin
                    grant     = 1'b1;
                    grant_id  = (bus.req0 && bus.req1) ? ~rr_last : bus.req1;
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (cnt_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_start = grant_id ? bus.start1 : bus.start0;
    assign grant_len   = grant_id ? bus.len1   : bus.len0;
    assign advance     = grant || ((state == BURST) && !cnt_done);
    assign id_nxt      = grant ? grant_id : id_p0;
    assign lin_nxt     = grant ? grant_start : lin_p0 + ADDR_W'(1);

`ifdef FFT_RD_BITREV_EN
    assign addr_nxt = id_nxt ? lin_nxt : bit_reverse(lin_nxt);
`else
    assign addr_nxt = lin_nxt;
`endif

    // p0: grant / address issue stage
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state   <= IDLE;
            armed   <= 1'b0;
            rr_last <= 1'b1;
            id_p0   <= 1'b0;
            cnt_p0  <= '0;
            addr_p0 <= '0;
            ack0_p0 <= 1'b0;
            ack1_p0 <= 1'b0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            id_p1   <= 1'b0;
        end else begin
            state   <= state_nxt;
            armed   <= 1'b1;
            ack0_p0 <= grant && !grant_id;
            ack1_p0 <= grant && grant_id;
            id_p0   <= id_nxt;
            if (grant) begin
                rr_last <= grant_id;
                cnt_p0  <= grant_len;
            end else if ((state == BURST) && !cnt_done) begin
                cnt_p0  <= cnt_p0 - ADDR_W'(1);
            end
            if (advance) begin
                addr_p0 <= addr_nxt;
            end
            // p1: data beat returning from RAM for the previous address
            vld_p1  <= (state == BURST);
            last_p1 <= (state == BURST) && cnt_done;
            id_p1   <= id_p0;
        end
    end

    // Linear counter is pure datapath; it is always reloaded at grant.
    always_ff @(posedge rd_clk) begin
        if (advance) begin
            lin_p0 <= lin_nxt;
        end
    end

    assign data_p1         = bus.ram_rd_data;
    assign bus.out_data    = data_p1;
    assign bus.out_vld     = vld_p1;
    assign bus.out_last    = last_p1;
    assign bus.out_id      = id_p1;
    assign bus.ram_rd_addr = addr_p0;
    assign bus.ack0        = ack0_p0;
    assign bus.ack1        = ack1_p0;
    assign bus.busy        = (state == BURST);
endmodule

// File: tb/tb_fft_ram_rd_arb.sv
// Self-checking bench for fft_ram_rd_arb: directed scenarios plus random traffic
// checked cycle by cycle against a burst-schedule reference model.
module tb_fft_ram_rd_arb;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int MAXC   = 8192;
    localparam int AMOD   = 1 << ADDR_W;

    logic rd_clk = 1'b0;
    logic rd_rst = 1'b0;

    fft_ram_rd_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fft_ram_rd_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .bus    (bus)
    );

    always #5 rd_clk = ~rd_clk;

    function automatic logic [31:0] memf(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0FF0;
    endfunction

    // RAM: data appears one cycle after the address
    always @(posedge rd_clk) bus.ram_rd_data <= memf(int'(bus.ram_rd_addr));

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int arb_ok  = 0;
    int next_arb = 0;
    int rr_last = 1;
    int last_grant = -100;
    bit hold0 = 0, hold1 = 0, rnd_mode = 0;

    bit          ex_ack0 [MAXC];
    bit          ex_ack1 [MAXC];
    bit          ex_busy [MAXC];
    bit          ex_vld  [MAXC];
    bit          ex_last [MAXC];
    int          ex_addr [MAXC];
    int          ex_id   [MAXC];
    logic [31:0] ex_data [MAXC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int map_addr(input int a, input int w);
`ifdef FFT_RD_BITREV_EN
        if (w == 0) begin
            int r = 0;
            for (int i = 0; i < ADDR_W; i++) if (a[i]) r |= 1 << (ADDR_W - 1 - i);
            return r;
        end
`endif
        return a + 0 * w;
    endfunction

    // Reference: a grant at edge e owns cycles e..e+len for addresses,
    // delivers beats one cycle later, and the next arbitration is at e+len+2.
    task automatic model_grant();
        int w, st, ln, a;
        if (bus.req0 && bus.req1) w = (rr_last == 0) ? 1 : 0;
        else                      w = bus.req1 ? 1 : 0;
        st = w ? int'(bus.start1) : int'(bus.start0);
        ln = w ? int'(bus.len1)   : int'(bus.len0);
        rr_last    = w;
        last_grant = cyc;
        if (w == 0) ex_ack0[cyc] = 1; else ex_ack1[cyc] = 1;
        for (int k = 0; k <= ln; k++) begin
            a = map_addr((st + k) % AMOD, w);
            ex_busy[cyc + k]     = 1;
            ex_addr[cyc + k]     = a;
            ex_vld[cyc + k + 1]  = 1;
            ex_id[cyc + k + 1]   = w;
            ex_data[cyc + k + 1] = memf(a);
        end
        ex_last[cyc + ln + 1] = 1;
        next_arb = cyc + ln + 2;
    endtask

    task automatic check_cycle();
        chk("ack0", bus.ack0, ex_ack0[cyc]);
        chk("ack1", bus.ack1, ex_ack1[cyc]);
        chk("busy", bus.busy, ex_busy[cyc]);
        chk("out_vld", bus.out_vld, ex_vld[cyc]);
        chk("out_last", bus.out_last, ex_last[cyc]);
        if (ex_busy[cyc]) chk("ram_rd_addr", bus.ram_rd_addr, ex_addr[cyc]);
        if (ex_vld[cyc]) begin
            chk("out_id", bus.out_id, ex_id[cyc]);
            chk("out_data", bus.out_data, ex_data[cyc]);
        end
    endtask

    function automatic logic [7:0] pick_len();
        return ($urandom_range(15) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(5));
    endfunction

    task automatic step();
        @(posedge rd_clk);
        cyc++;
        if (!rd_rst && cyc >= arb_ok && cyc >= next_arb && (bus.req0 || bus.req1)) model_grant();
        #1;
        check_cycle();
        // requesters drop after their ack and scramble start/len while idle
        if (ex_ack0[cyc] && !hold0) begin
            bus.req0 = 0; bus.start0 = 8'($urandom); bus.len0 = 8'($urandom);
        end
        if (ex_ack1[cyc] && !hold1) begin
            bus.req1 = 0; bus.start1 = 8'($urandom); bus.len1 = 8'($urandom);
        end
        if (rnd_mode) begin
            if (!bus.req0 && $urandom_range(3) == 0) begin
                bus.req0 = 1; bus.start0 = 8'($urandom); bus.len0 = pick_len();
            end
            if (!bus.req1 && $urandom_range(3) == 0) begin
                bus.req1 = 1; bus.start1 = 8'($urandom); bus.len1 = pick_len();
            end
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((cyc < next_arb || bus.req0 || bus.req1) && n < 600) begin
            step();
            n++;
        end
        chk("idle_wait_expired", n >= 600, 0);
    endtask

    task automatic do_reset(input int ncyc);
        rd_rst = 1; bus.req0 = 0; bus.req1 = 0;
        #1;
        chk("rst_ack0", bus.ack0, 0);
        chk("rst_ack1", bus.ack1, 0);
        chk("rst_vld", bus.out_vld, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_id", bus.out_id, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_addr", bus.ram_rd_addr, 0);
        for (int i = cyc + 1; i < MAXC; i++) begin
            ex_ack0[i] = 0; ex_ack1[i] = 0; ex_busy[i] = 0; ex_vld[i] = 0; ex_last[i] = 0;
        end
        repeat (ncyc) begin
            @(posedge rd_clk);
            cyc++;
            #1;
            chk("rst_hold_vld", bus.out_vld, 0);
        end
        rd_rst   = 0;
        arb_ok   = cyc + 2;
        next_arb = 0;
        rr_last  = 1;
    endtask

    initial begin
        #(MAXC * 10 * 3);
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int n;
        bus.req0 = 0; bus.req1 = 0;
        bus.start0 = 0; bus.start1 = 0; bus.len0 = 0; bus.len1 = 0;
        do_reset(3);

        // single 4-word burst from requester 0
        bus.start0 = 8'h10; bus.len0 = 8'd3; bus.req0 = 1;
        wait_idle();

        // both held from reset, one-word bursts: alternating grants
        do_reset(2);
        hold0 = 1; hold1 = 1;
        bus.start0 = 8'h40; bus.len0 = 0; bus.start1 = 8'h80; bus.len1 = 0;
        bus.req0 = 1; bus.req1 = 1;
        repeat (12) step();
        hold0 = 0; hold1 = 0;
        bus.req0 = 0; bus.req1 = 0;
        wait_idle();

        // address wrap on requester 1
        bus.start1 = 8'hFE; bus.len1 = 8'd3; bus.req1 = 1;
        wait_idle();

        // reset during the third cycle of an 8-word burst, then a fresh request
        bus.start0 = 8'h20; bus.len0 = 8'd7; bus.req0 = 1;
        n = 0;
        while (!(cyc == last_grant + 2 && ex_busy[cyc]) && n < 20) begin
            step();
            n++;
        end
        chk("burst_start_expired", n >= 20, 0);
        do_reset(2);
        bus.start1 = 8'h33; bus.len1 = 8'd1; bus.req1 = 1;
        wait_idle();

        // addressing mode check for requester 0
        bus.start0 = 8'h01; bus.len0 = 8'd2; bus.req0 = 1;
        wait_idle();

        // 256-word burst, requester 1 arrives mid-burst
        bus.start0 = 8'($urandom); bus.len0 = 8'd255; bus.req0 = 1;
        repeat (10) step();
        bus.start1 = 8'h05; bus.len1 = 8'd2; bus.req1 = 1;
        wait_idle();

        // random traffic with occasional resets
        rnd_mode = 1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(499) == 0) do_reset(1 + $urandom_range(2));
            step();
        end
        rnd_mode = 0;
        wait_idle();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fft_ram_rd_arb.md
FFT_RAM_RD_ARB -- requirements
Module: fft_ram_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, FFT RAM read address width.
REQ-002 SHALL have parameter DATA_W, default 32, FFT RAM read data width.
REQ-003 SHALL have port rd_clk  input  1  read-side clock; all logic on rising edge.
REQ-004 SHALL have port rd_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  burst request from requester 0/1; level, held until ack.
REQ-006 SHALL have ports start0/start1  input  ADDR_W  burst start address.
REQ-007 SHALL have ports len0/len1  input  ADDR_W  burst length minus one (0 = 1 word, 255 = 256 words).
REQ-008 SHALL have ports ack0/ack1  output  1  one-cycle grant pulse; start/len sampled this cycle.
REQ-009 SHALL have port ram_rd_addr  output  ADDR_W  registered address to RAM read port.
REQ-010 SHALL have port ram_rd_data  input  DATA_W  RAM read data, one cycle after address.
REQ-011 SHALL have port out_data  output  DATA_W  ram_rd_data passed through combinationally.
REQ-012 SHALL have ports out_vld/out_id/out_last  output  1  data valid, owning requester, last word of burst.
REQ-013 SHALL have port busy  output  1  high while state is BURST.

Function
REQ-014 SHALL implement FSM with two states: IDLE, BURST.
REQ-015 IDLE: if any req high at a rising edge, SHALL move to BURST, pulse ack of winner in the first BURST cycle, and present start of winner on ram_rd_addr in that cycle.
REQ-016 Arbitration SHALL be round-robin: both requests high -> grant the requester not granted last; after reset requester 0 has priority.
REQ-017 BURST: ram_rd_addr SHALL increment by 1 each cycle, modulo 2^ADDR_W (255 -> 0 wrap, no error).
REQ-018 A burst SHALL issue exactly len+1 addresses, then return to IDLE; one-cycle address gap between consecutive bursts.
REQ-019 out_vld SHALL be high exactly one cycle after each issued address; out_id equals granted requester; out_last high with the final word only.
REQ-020 ack SHALL pulse exactly once per burst; requests deasserted before being sampled in IDLE are ignored.
REQ-021 Requests arriving during BURST SHALL be held and arbitrated at the next IDLE edge.
REQ-022 start/len SHALL be latched at grant; later changes to them do not affect the active burst.
REQ-023 Read latency from grant-cycle address to first out_vld SHALL be 1 cycle.

Reset
REQ-024 rd_rst high SHALL immediately force IDLE, ram_rd_addr=0, ack0=ack1=0, out_vld=0, out_id=0, out_last=0, busy=0, round-robin pointer to "requester 0 first".
REQ-025 Reset mid-burst SHALL abort the burst with no further out_vld; pending data beat is discarded.
REQ-026 After reset release, first grant SHALL occur no earlier than the second rising edge.

Configuration
REQ-027 Macro FFT_RD_BITREV_EN: when defined, addresses issued for requester 0 SHALL be the ADDR_W-bit bit-reversal of the linear counter (start and increment applied before reversal); requester 1 unchanged.
REQ-028 Without FFT_RD_BITREV_EN, both requesters SHALL use linear addressing and no reversal logic SHALL exist.

Verification
REQ-029 req0=1, start0=0x10, len0=3 alone -> ack0 one cycle; addresses 0x10..0x13; out_vld 4 cycles, out_id=0, out_last on 4th.
REQ-030 req0=req1=1 held after reset, len=0 each -> grants order 0,1,0,1; one idle address cycle between bursts.
REQ-031 req1=1, start1=0xFE, len1=3 -> addresses 0xFE,0xFF,0x00,0x01; 4 valid beats, out_id=1.
REQ-032 rd_rst asserted on 3rd cycle of 8-word burst -> all outputs 0 at once; no further out_vld; new request after release served from its own start.
REQ-033 With FFT_RD_BITREV_EN, req0 start0=0x01, len0=2 -> addresses 0x80,0x40,0xC0; same stimulus without macro -> 0x01,0x02,0x03.
REQ-034 len0=255 burst with req1 raised mid-burst -> 256 beats for requester 0 uninterrupted, then ack1.
